fp32_to_fp16_lane_pipe: RTL and testbench
=========================================

// Module: fp32_to_fp16_lane_pipe
// PURPOSE
//  Multi-lane, 2-stage pipelined FP32->FP16 narrowing converter for the MAC result path.
//  Successor to the single-word combinational converter; adds per-beat rounding mode, a
//  valid/ready stream with backpressure and per-lane IEEE flags. Adds sticky accumulated
//  flags. Per-beat mode=1 passes FP32 words through untouched.
// PARAMETERS
//  LANES  4  number of independent 32-bit lanes per beat (>=1)
// PORTS
//  clk         in   1         single clock; all state updates on rising edge
//  rst         in   1         synchronous, active-high reset
//  in_valid    in   1         input beat valid
//  in_ready    out  1         converter can accept a beat this cycle
//  in_data     in   32*LANES  lane i = in_data[32*i+:32], FP32
//  in_mode     in   1         1=passthrough, 0=convert
//  in_rm       in   3         0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4..7 treated as RNE
//  out_valid   out  1         output beat valid
//  out_ready   in   1         downstream accepts beat
//  out_data    out  32*LANES  convert: {16'h0,fp16} per lane; passthrough: input word
//  out_flags   out  5*LANES   per lane {NV,DZ,OF,UF,NX}; DZ always 0
//  acc_flags   out  5         sticky OR of all lane flags of every fired output beat
//  flags_clr   in   1         clear acc_flags
// BEHAVIOUR
//  Reset: out_valid=0, both stage valids=0, out_data=0, out_flags=0, acc_flags=0; in_ready=1
//    one cycle after rst drops. rst mid-stream discards all in-flight beats, no output.
//  Pipeline: S1 = decode/align/sticky, S2 = round/pack (S2 regs drive outputs).
//    Latency 2 cycles in->out; throughput 1 beat/cycle when out_ready=1.
//  Handshake: fire_in = in_valid&in_ready; fire_out = out_valid&out_ready.
//    s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
//    Stalled stages hold data stable; out_data/out_flags stable while out_valid&!out_ready.
//    No drop, duplication or reordering. in_mode/in_rm sampled with the beat.
//  Conversion per lane (mode=0), e=exp32, m=man32, h=e-112:
//    Inf (e=FF,m=0)       -> {s,5'h1F,0}, no flags.
//    NaN                  -> {s,5'h1F,1'b1,m[21:13]} (quieted); NV=1 iff m[22]=0.
//    Zero                 -> {s,15'h0}, no flags.
//    FP32 subnormal       -> treated as |x|<2^-24 tiny: rounds to 0 or min subnormal 0x0001
//                            per rm (RUP +x -> 0x0001; RDN -x -> 0x8001); UF=NX=1.
//    h>=31, or carry to 31 -> overflow: RNE ->Inf; RTZ ->0x7BFF|s; RDN: +->7BFF,-->FC00;
//                            RUP: +->7C00,-->FBFF. OF=NX=1.
//    1<=h<=30             -> 10-bit mantissa m[22:13], guard m[12], sticky |m[11:0].
//    h<=0                 -> 24-bit {1,m} >> (14-h) (shift>=25 collapses to sticky only);
//                            guard = last shifted-out bit, sticky = OR of rest.
//    Rounding increment: RNE g&(st|lsb); RTZ 0; RDN s&(g|st); RUP !s&(g|st).
//    Mantissa carry bumps exponent (subnormal 0x3FF+1 -> 0x0400, normal).
//    NX = g|st (or overflow). UF = NX & result exponent field 0 (post-round tininess).
//  Passthrough (mode=1): out_data=in_data, out_flags=0.
//  Sticky: on fire_out, acc_flags <= (flags_clr ? 0 : acc_flags) | OR of lanes' out_flags;
//    flags_clr without fire_out -> 0.
// TESTING
//  Lane0 0x3F800000 rm=RNE -> 0x00003C00 flags 0 two cycles after fire_in.
//  0x477FF000 rm=RNE -> 0x7C00 OF,NX; rm=RTZ -> 0x7BFF OF,NX; 0xC77FF000 RDN -> 0xFC00.
//  0x33000000 RNE -> 0x0000 UF,NX (tie-to-even); 0x33000001 RNE -> 0x0001 UF,NX;
//    0x387FE000 RNE -> 0x0400 NX only.
//  0x7F800001 -> 0x7E00 NV; 0x7FC00000 -> 0x7E00 no flags; mode=1 0x7F800001 -> same word.
//  Backpressure: 4 back-to-back beats, out_ready=0 for 5 cycles -> in_ready=0 after 2 beats
//    held; release -> 4 beats out in order, values unchanged, acc_flags = OR of their flags.
//  rst asserted with 2 beats in flight -> out_valid=0 next cycle, acc_flags=0, no stale beat;
//    flags_clr with fire_out -> acc_flags equals that beat's flags only.

Source files
------------

// File: rtl/fp32_to_fp16_lane_pipe.sv
// fp32_to_fp16_lane_pipe: multi-lane 2-stage FP32->FP16 narrowing converter with valid/ready and sticky flags
module fp32_to_fp16_lane_pipe #(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_data,
  input  logic                in_mode,
  input  logic [2:0]          in_rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data,
  output logic [5*LANES-1:0]  out_flags,
  output logic [4:0]          acc_flags,
  input  logic                flags_clr
);
  typedef struct packed {
    logic        sp;
    logic [15:0] res;
    logic [4:0]  fl;
    logic [14:0] pre;
    logic        g;
    logic        st;
  } dec_t;
  function automatic logic to_inf(input logic s, input logic [2:0] rm);
    return rm == 3'd1 ? 1'b0 : rm == 3'd2 ? s : rm == 3'd3 ? !s : 1'b1;
  endfunction
  // Stage-1 work: classify, align to the fp16 grid and collect guard/sticky.
  // Magnitudes at or above 65520 are flagged overflow in every rounding mode.
  function automatic dec_t decode(input logic [31:0] x, input logic [2:0] rm);
    dec_t d;
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    logic signed [9:0] h;
    logic [4:0] sh;
    logic [34:0] v;
    s = x[31];
    e = x[30:23];
    m = x[22:0];
    h = $signed({2'b0, e}) - 10'sd112;
    sh = 5'(10'sd14 - h);
    v = 35'({1'b1, m, 25'b0} >> sh);
    d = '0;
    if (e == 8'hFF) begin
      d.sp = 1'b1;
      d.res = m == '0 ? {s, 15'h7C00} : {s, 6'h3F, m[21:13]};
      d.fl = {~m[22] & |m, 4'h0};
    end else if (e == 8'h00) begin
      d.sp = m == '0;
      d.res = {s, 15'h0};
      d.st = |m;
    end else if (h >= 10'sd31 || (h == 10'sd30 && &m[22:12])) begin
      d.sp = 1'b1;
      d.res = {s, to_inf(s, rm) ? 15'h7C00 : 15'h7BFF};
      d.fl = 5'b00101;
    end else if (h >= 10'sd1) begin
      d.pre = {h[4:0], m[22:13]};
      d.g = m[12];
      d.st = |m[11:0];
    end else if (h > -10'sd11) begin
      d.pre = {5'h0, v[34:25]};
      d.g = v[24];
      d.st = |v[23:0];
    end else begin
      d.st = 1'b1;
    end
    return d;
  endfunction
  // Stage-2 work: apply the rounding increment and pack; a carry into exponent 31 overflows.
  function automatic logic [20:0] round_pack(input dec_t d, input logic s, input logic [2:0] rm);
    logic inc;
    logic nx;
    logic [14:0] sum;
    inc = rm == 3'd1 ? 1'b0 : rm == 3'd2 ? s & (d.g | d.st) : rm == 3'd3 ? !s & (d.g | d.st) : d.g & (d.st | d.pre[0]);
    nx = d.g | d.st;
    sum = d.pre + 15'(inc);
    if (d.sp) return {d.fl, d.res};
    if (&sum[14:10]) return {5'b00101, s, to_inf(s, rm) ? 15'h7C00 : 15'h7BFF};
    return {3'b000, nx & ~|sum[14:10], nx, s, sum};
  endfunction
  logic s2_adv, s1_adv, fire_out, s1_valid, s1_mode;
  logic [2:0] s1_rm;
  logic [32*LANES-1:0] s1_raw, s2_data_n;
  logic [5*LANES-1:0] s2_flags_n;
  dec_t [LANES-1:0] dec_n, s1_dec;
  logic [LANES-1:0][20:0] rp;
  logic [4:0] or_flags;
  assign s2_adv = !out_valid | out_ready;
  assign s1_adv = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign fire_out = out_valid & out_ready;
  // Decode every lane of the incoming beat.
  always_comb begin
    dec_n = '0;
    for (int i = 0; i < LANES; i++) dec_n[i] = decode(in_data[32*i+:32], in_rm);
  end
  // Round/pack each lane, or pass the raw word through.
  always_comb begin
    rp = '0;
    s2_data_n = '0;
    s2_flags_n = '0;
    for (int i = 0; i < LANES; i++) begin
      rp[i] = round_pack(s1_dec[i], s1_raw[32*i+31], s1_rm);
      s2_data_n[32*i+:32] = s1_mode ? s1_raw[32*i+:32] : {16'h0, rp[i][15:0]};
      s2_flags_n[5*i+:5] = s1_mode ? 5'h0 : rp[i][20:16];
    end
  end
  // OR of all lane flags of the beat currently presented.
  always_comb begin
    or_flags = '0;
    for (int i = 0; i < LANES; i++) or_flags = or_flags | out_flags[5*i+:5];
  end
  // Stage 1 register: captures a beat whenever it can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_mode <= in_mode;
      s1_rm <= in_rm;
      s1_raw <= in_data;
      s1_dec <= dec_n;
    end
  end
  // Stage 2 register drives the outputs and holds them while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data_n;
        out_flags <= s2_flags_n;
      end
    end
  end
  // Sticky flags accumulate on each delivered beat; a clear in the same cycle keeps only that beat.
  always_ff @(posedge clk) begin
    acc_flags <= rst ? 5'h0 : fire_out ? ((flags_clr ? 5'h0 : acc_flags) | or_flags) : flags_clr ? 5'h0 : acc_flags;
  end
endmodule

// File: tb/tb_fp32_to_fp16_lane_pipe.sv
// tb_fp32_to_fp16_lane_pipe: table, random and corner-sequence bench with an arithmetic reference model
module tb_fp32_to_fp16_lane_pipe;
  localparam int L = 4;
  typedef struct packed {
    logic [31:0] x;
    logic [2:0]  rm;
    logic        mode;
    logic [31:0] d;
    logic [4:0]  f;
  } vec_t;
  typedef struct packed {
    logic [32*L-1:0] d;
    logic [5*L-1:0]  f;
  } beat_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mode, out_valid, out_ready, flags_clr;
  logic [2:0] in_rm;
  logic [32*L-1:0] in_data, out_data;
  logic [5*L-1:0] out_flags;
  logic [4:0] acc_flags;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_on = 1'b0;
  bit bp_done;
  logic [4:0] exp_acc = '0;
  beat_t sb[$];
  vec_t tbl[$];
  fp32_to_fp16_lane_pipe #(.LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .acc_flags(acc_flags), .flags_clr(flags_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference conversion from the real value: scale onto the fp16 grid and round the quotient.
  function automatic void model(input logic [31:0] x, input logic [2:0] rm, input logic mode,
                                output logic [31:0] d, output logic [4:0] f);
    logic s;
    int e, m, ex;
    real a, n, fr;
    longint fl, code;
    bit up, of, nx;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    f = 5'h0;
    if (mode) begin
      d = x;
    end else if (e == 255) begin
      d = m == 0 ? {16'h0, s, 15'h7C00} : {16'h0, s, 5'h1F, 1'b1, x[21:13]};
      f = {m != 0 && !x[22], 4'h0};
    end else if (e == 0 && m == 0) begin
      d = {16'h0, s, 15'h0};
    end else begin
      a = (e == 0) ? m * 2.0 ** (-149) : (8388608.0 + m) * 2.0 ** (e - 150);
      ex = (e == 0 || e - 127 < -14) ? -14 : e - 127;
      n = a / 2.0 ** (ex - 10);
      fl = longint'($floor(n));
      fr = n - fl;
      case (rm)
        3'd1: up = 1'b0;
        3'd2: up = s && fr > 0.0;
        3'd3: up = !s && fr > 0.0;
        default: up = fr > 0.5 || (fr == 0.5 && fl % 2 == 1);
      endcase
      code = (ex + 14) * 1024 + fl + longint'(up);
      of = code >= 'h7C00 || a >= 65520.0;
      nx = fr > 0.0 || of;
      if (of) code = (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) ? 'h7BFF : 'h7C00;
      d = {16'h0, s, code[14:0]};
      f = {2'b00, of, nx && !of && code < 1024, nx};
    end
  endfunction
  function automatic beat_t expect_beat(input logic [32*L-1:0] data, input logic mode, input logic [2:0] rm);
    beat_t b;
    logic [31:0] w;
    logic [4:0] f;
    for (int i = 0; i < L; i++) begin
      model(data[32*i+:32], rm, mode, w, f);
      b.d[32*i+:32] = w;
      b.f[5*i+:5] = f;
    end
    return b;
  endfunction
  function automatic logic [4:0] or5(input logic [5*L-1:0] f);
    logic [4:0] r = '0;
    for (int i = 0; i < L; i++) r = r | f[5*i+:5];
    return r;
  endfunction
  function automatic logic [31:0] rnd_word();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k == 0) w[30:23] = 8'hFF;
    if (k == 1) w[30:23] = 8'h00;
    if (k == 2) w[30:0] = '0;
    if (k >= 3 && k <= 6) w[30:23] = 8'($urandom_range(98, 145));
    if (k == 3) w[12:0] = 13'h1000;
    if (k == 7) w[30:23] = 8'($urandom_range(98, 113));
    if (k == 8) begin w[30:23] = 8'h8E; w[22:12] = 11'h7FF; end
    return w;
  endfunction
  function automatic void add(input logic [31:0] x, input logic [2:0] rm, input logic mode,
                              input logic [31:0] d, input logic [4:0] f);
    tbl.push_back({x, rm, mode, d, f});
  endfunction
  // Present one beat (called at posedge+1) and hold it until accepted; queue its expectation.
  task automatic send(input logic [32*L-1:0] data, input logic mode, input logic [2:0] rm, input beat_t exp);
    int t = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = data;
    in_mode = mode;
    in_rm = rm;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    check("accept", ok, 1'b1);
    if (ok) sb.push_back(exp);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", sb.size(), 0);
  endtask
  function automatic logic [32*L-1:0] splat(input logic [31:0] w);
    return {L{w}};
  endfunction
  // Scoreboard and sticky-flag model, sampled on the falling edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en) check("acc_flags", acc_flags, exp_acc);
      if (rst) begin
        sb.delete();
        exp_acc = '0;
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected beat", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("beat data", out_data, e.d);
          check("beat flags", out_flags, e.f);
          exp_acc = (flags_clr ? 5'h0 : exp_acc) | or5(e.f);
        end
      end else if (flags_clr) begin
        exp_acc = '0;
      end
    end
  end
  // Random backpressure and flag clears during the random phase.
  initial begin
    wait (rand_on);
    while (rand_on) begin
      @(posedge clk);
      #1;
      out_ready = $urandom_range(0, 3) != 0;
      flags_clr = $urandom_range(0, 15) == 0;
    end
  end
  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    logic [32*L-1:0] d;
    beat_t b, bp[4];
    logic [4:0] bp_or;
    logic mode;
    logic [2:0] rm;
    add(32'h3F800000, 3'd0, 1'b0, 32'h00003C00, 5'h00);
    add(32'h477FF000, 3'd0, 1'b0, 32'h00007C00, 5'h05);
    add(32'h477FF000, 3'd1, 1'b0, 32'h00007BFF, 5'h05);
    add(32'hC77FF000, 3'd2, 1'b0, 32'h0000FC00, 5'h05);
    add(32'h33000000, 3'd0, 1'b0, 32'h00000000, 5'h03);
    add(32'h33000001, 3'd0, 1'b0, 32'h00000001, 5'h03);
    add(32'h387FE000, 3'd0, 1'b0, 32'h00000400, 5'h01);
    add(32'h7F800001, 3'd0, 1'b0, 32'h00007E00, 5'h10);
    add(32'h7FC00000, 3'd0, 1'b0, 32'h00007E00, 5'h00);
    add(32'h7F800001, 3'd0, 1'b1, 32'h7F800001, 5'h00);
    add(32'h00000001, 3'd3, 1'b0, 32'h00000001, 5'h03);
    add(32'h80000001, 3'd2, 1'b0, 32'h00008001, 5'h03);
    add(32'h00000001, 3'd0, 1'b0, 32'h00000000, 5'h03);
    add(32'h80000000, 3'd0, 1'b0, 32'h00008000, 5'h00);
    add(32'hFF800000, 3'd0, 1'b0, 32'h0000FC00, 5'h00);
    add(32'h30000000, 3'd3, 1'b0, 32'h00000001, 5'h03);
    add(32'h477FF000, 3'd5, 1'b0, 32'h00007C00, 5'h05);
    add(32'h3F801000, 3'd0, 1'b0, 32'h00003C00, 5'h01);
    add(32'h3F801000, 3'd3, 1'b0, 32'h00003C01, 5'h01);
    add(32'h477FE000, 3'd1, 1'b0, 32'h00007BFF, 5'h00);
    add(32'hC7800000, 3'd3, 1'b0, 32'h0000FBFF, 5'h05);
    add(32'h387FC000, 3'd0, 1'b0, 32'h000003FF, 5'h00);
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 1'b0;
    in_rm = 3'd0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, '0);
    check("reset out_flags", out_flags, '0);
    check("reset acc_flags", acc_flags, 5'h0);
    check("reset in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 mon_en = 1'b1;
    out_ready = 1'b1;
    // Table vectors on lane 0, random words on the other lanes.
    foreach (tbl[k]) begin
      for (int i = 0; i < L; i++) d[32*i+:32] = rnd_word();
      d[31:0] = tbl[k].x;
      b = expect_beat(d, tbl[k].mode, tbl[k].rm);
      b.d[31:0] = tbl[k].d;
      b.f[4:0] = tbl[k].f;
      send(d, tbl[k].mode, tbl[k].rm, b);
    end
    drain();
    // Random beats with random gaps, backpressure and clears.
    rand_on = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < L; i++) d[32*i+:32] = rnd_word();
      mode = $urandom_range(0, 7) == 0;
      rm = 3'($urandom_range(0, 7));
      send(d, mode, rm, expect_beat(d, mode, rm));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    flags_clr = 1'b0;
    drain();
    // Backpressure: four back-to-back beats against a stalled sink.
    out_ready = 1'b0;
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    bp_or = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < L; i++) d[32*i+:32] = rnd_word();
      d[31:0] = k == 0 ? 32'h477FF000 : k == 1 ? 32'h7F800001 : 32'h33000001;
      bp[k] = expect_beat({d[32*L-1:32], d[31:0]}, 1'b0, 3'd0);
      bp[k].d = d;
      bp_or = bp_or | or5(bp[k].f);
    end
    for (int k = 0; k < 4; k++) begin
      b = bp[k];
      bp[k] = expect_beat(b.d, 1'b0, 3'd0);
      bp[k].d = b.d;
    end
    bp_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(bp[k].d, 1'b0, 3'd0, expect_beat(bp[k].d, 1'b0, 3'd0));
        bp_done = 1'b1;
      end
    join_none
    repeat (2) @(negedge clk);
    b = expect_beat(bp[0].d, 1'b0, 3'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp in_ready", in_ready, 1'b0);
      check("bp out_valid", out_valid, 1'b1);
      check("bp held data", out_data, b.d);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int t = 0; t < 100 && !bp_done; t++) begin @(posedge clk); #1; end
    check("bp sender done", bp_done, 1'b1);
    drain();
    check("bp acc_flags", acc_flags, bp_or);
    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d = splat(rnd_word());
      send(d, 1'b0, 3'd0, expect_beat(d, 1'b0, 3'd0));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 1'b0);
    check("rst acc_flags", acc_flags, 5'h0);
    check("rst out_data", out_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post-rst out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    // flags_clr coinciding with a delivered beat keeps only that beat's flags.
    d = splat(32'h477FF000);
    send(d, 1'b0, 3'd0, expect_beat(d, 1'b0, 3'd0));
    drain();
    check("pre-clr acc_flags", acc_flags, 5'h05);
    out_ready = 1'b0;
    d = splat(32'h7F800001);
    send(d, 1'b0, 3'd0, expect_beat(d, 1'b0, 3'd0));
    repeat (2) @(negedge clk);
    check("clr out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 flags_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    @(negedge clk);
    check("clr acc_flags", acc_flags, 5'h10);
    @(posedge clk);
    #1 drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
